// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch/data requester handshakes and the shared 64-bit memory beat port.
// The arbiter uses the slave view; requesters and the memory use the master view.
interface mem_port_arbiter_if;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_done;
  logic        f_err;
  logic [79:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_done;
  logic        d_err;
  logic [63:0] d_rdata;
  logic        f_wait;
  logic        m_wait;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output f_done, f_err, f_rdata, d_done, d_err, d_rdata, f_wait, m_wait,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  f_done, f_err, f_rdata, d_done, d_err, d_rdata, f_wait, m_wait,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between 10-byte fetch reads (two beats) and 8-byte data
// accesses; data wins ties, fetches run to completion, each beat has an ack timeout.
module mem_port_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_port_arbiter_if.slave    bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [64:0]   MEM_LIM  = 65'(MEM_BYTES);

  typedef enum logic [2:0] {IDLE, D_ACC, F_BEAT0, F_BEAT1, RESP} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_mem_req, w_mem_req;
  logic          r_mem_we, w_mem_we;
  logic [63:0]   r_mem_addr, w_mem_addr;
  logic [63:0]   r_mem_wdata, w_mem_wdata;
  logic [79:0]   r_f_rdata, w_f_rdata;
  logic [63:0]   r_d_rdata, w_d_rdata;
  logic          r_owner_d, w_owner_d;
  logic          r_err, w_err;
  logic          r_f_done, w_f_done;
  logic          r_f_err, w_f_err;
  logic          r_d_done, w_d_done;
  logic          r_d_err, w_d_err;
  logic          w_enter_resp;
  logic          w_d_oob, w_f_oob;

  // 65-bit sums so that a wrapping address still reads as out of range
  assign w_d_oob = ({1'b0, bus.d_addr} + 65'd8)  > MEM_LIM;
  assign w_f_oob = ({1'b0, bus.f_addr} + 65'd10) > MEM_LIM;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
      r_owner_d   <= 1'b0;
      r_err       <= 1'b0;
      r_f_done    <= 1'b0;
      r_f_err     <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_f_rdata   <= w_f_rdata;
      r_d_rdata   <= w_d_rdata;
      r_owner_d   <= w_owner_d;
      r_err       <= w_err;
      r_f_done    <= w_f_done;
      r_f_err     <= w_f_err;
      r_d_done    <= w_d_done;
      r_d_err     <= w_d_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_f_rdata   = r_f_rdata;
    w_d_rdata   = r_d_rdata;
    w_owner_d   = r_owner_d;
    w_err       = r_err;
    case (r_state)
      IDLE: begin
        if (bus.d_req) begin
          w_owner_d = 1'b1;
          w_err     = w_d_oob;
          if (w_d_oob) begin
            w_state = RESP;
          end else begin
            w_state     = D_ACC;
            w_cnt       = '0;
            w_mem_req   = 1'b1;
            w_mem_we    = bus.d_we;
            w_mem_addr  = bus.d_addr;
            w_mem_wdata = bus.d_wdata;
          end
        end else if (bus.f_req) begin
          w_owner_d = 1'b0;
          w_err     = w_f_oob;
          if (w_f_oob) begin
            w_state = RESP;
          end else begin
            w_state    = F_BEAT0;
            w_cnt      = '0;
            w_mem_req  = 1'b1;
            w_mem_we   = 1'b0;
            w_mem_addr = bus.f_addr;
          end
        end
      end
      D_ACC, F_BEAT0, F_BEAT1: begin
        if (bus.mem_ack) begin
          w_cnt = '0;
          if (r_state == D_ACC) begin
            if (!r_mem_we) w_d_rdata = bus.mem_rdata;
            w_mem_req = 1'b0;
            w_mem_we  = 1'b0;
            w_state   = RESP;
          end else if (r_state == F_BEAT0) begin
            // mem_req stays high: the second beat starts right away
            w_f_rdata[63:0] = bus.mem_rdata;
            w_mem_addr      = r_mem_addr + 64'd8;
            w_state         = F_BEAT1;
          end else begin
            w_f_rdata[79:64] = bus.mem_rdata[15:0];
            w_mem_req        = 1'b0;
            w_state          = RESP;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_mem_req = 1'b0;
          w_mem_we  = 1'b0;
          w_err     = 1'b1;
          w_state   = RESP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase

    // done is registered on entry, so it is high exactly during the RESP cycle
    w_enter_resp = (w_state == RESP) && (r_state != RESP);
    w_d_done     = w_enter_resp & w_owner_d;
    w_f_done     = w_enter_resp & ~w_owner_d;
    w_d_err      = w_d_done & w_err;
    w_f_err      = w_f_done & w_err;
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.f_done    = r_f_done;
  assign bus.f_err     = r_f_err;
  assign bus.f_rdata   = r_f_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.f_wait    = bus.f_req & ~r_f_done;
  assign bus.m_wait    = bus.d_req & ~r_d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-array memory model with optional ack stall,
// hand-computed latencies, data and error flags.
module tb_mem_port_arbiter;
  logic clk;
  logic reset_n;
  logic ack_en;
  logic stray_ack;
  int   total;
  int   bad;
  int   nbeat;
  logic [63:0] beat_log [0:255];
  logic [7:0]  mem [0:1023];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_BYTES(1024), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory when ack_en is set; reads past the array return 0
  always_comb begin
    logic [63:0] idx;
    bus.mem_ack   = (ack_en & bus.mem_req) | stray_ack;
    bus.mem_rdata = '0;
    for (int j = 0; j < 8; j++) begin
      idx = bus.mem_addr + 64'(j);
      if (idx < 64'd1024) bus.mem_rdata[8*j +: 8] = mem[idx[9:0]];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack) begin
      beat_log[nbeat[7:0]] <= bus.mem_addr;
      nbeat <= nbeat + 1;
      if (bus.mem_we) begin
        for (int j = 0; j < 8; j++) begin
          if (bus.mem_addr + 64'(j) < 64'd1024)
            mem[10'(bus.mem_addr + 64'(j))] <= bus.mem_wdata[8*j +: 8];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_xact(input bit is_f, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, output int lat, output int reqcyc,
                          output bit err, output bit wait_ok);
    bit done;
    @(posedge clk); #1;
    if (is_f) begin
      bus.f_req = 1'b1; bus.f_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end
    lat = 0; reqcyc = 0; err = 1'b0; wait_ok = 1'b1; done = 1'b0;
    @(negedge clk);
    if ((is_f ? bus.f_wait : bus.m_wait) !== 1'b1) wait_ok = 1'b0;
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.mem_req) reqcyc++;
      done = is_f ? bus.f_done : bus.d_done;
      if (done) begin
        err = is_f ? bus.f_err : bus.d_err;
        if ((is_f ? bus.f_wait : bus.m_wait) !== 1'b0) wait_ok = 1'b0;
      end else if ((is_f ? bus.f_wait : bus.m_wait) !== 1'b1) begin
        wait_ok = 1'b0;
      end
    end
    if (!done) check("xact_no_done", 80'd0, 80'd1);
    @(posedge clk); #1;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    $display("xact %s addr=%0h lat=%0d reqcyc=%0d err=%0d", is_f ? "F" : "D", addr, lat, reqcyc, err);
  endtask

  int lat, reqcyc, b0, dl, fl, cyc;
  bit err, wok, fw_ok, quiet;

  initial begin
    total = 0; bad = 0; nbeat = 0;
    reset_n = 1'b0; ack_en = 1'b1; stray_ack = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",  80'(bus.mem_req),  80'd0);
    check("rst_dones",    80'({bus.f_done, bus.d_done, bus.f_err, bus.d_err}), 80'd0);
    check("rst_mem_addr", 80'(bus.mem_addr), 80'd0);
    check("rst_f_rdata",  bus.f_rdata,       80'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Data write then read at 8
    run_xact(1'b0, 1'b1, 64'd8, 64'd15, lat, reqcyc, err, wok);
    check("dwr_lat", 80'(lat), 80'd2);
    check("dwr_err", 80'(err), 80'd0);
    check("dwr_mwait", 80'(wok), 80'd1);
    run_xact(1'b0, 1'b0, 64'd8, 64'd0, lat, reqcyc, err, wok);
    check("drd_lat", 80'(lat), 80'd2);
    check("drd_rdata", 80'(bus.d_rdata), 80'd15);
    check("drd_err", 80'(err), 80'd0);

    // Fetch at 10: bytes 10..19 = 30 F2 08 00 ...
    run_xact(1'b0, 1'b1, 64'd10, 64'h0000_0000_0008_F230, lat, reqcyc, err, wok);
    run_xact(1'b0, 1'b1, 64'd18, 64'd0, lat, reqcyc, err, wok);
    b0 = nbeat;
    run_xact(1'b1, 1'b0, 64'd10, 64'd0, lat, reqcyc, err, wok);
    check("f_lat", 80'(lat), 80'd3);
    check("f_beat0", 80'(beat_log[b0[7:0]]), 80'd10);
    check("f_beat1", 80'(beat_log[8'(b0 + 1)]), 80'd18);
    check("f_rdata", bus.f_rdata, 80'h0000_0000_0000_0008_F230);
    check("f_err", 80'(err), 80'd0);
    check("f_fwait", 80'(wok), 80'd1);

    // Collision: both requests rise together
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd8;
    bus.f_req = 1'b1; bus.f_addr = 64'd10;
    dl = 0; fl = 0; fw_ok = 1'b1; cyc = 0;
    while (fl == 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (dl != 0) bus.d_req = 1'b0;
      @(negedge clk);
      if (bus.d_done && dl == 0) dl = cyc;
      if (bus.f_done) fl = cyc;
      else if (bus.f_wait !== 1'b1) fw_ok = 1'b0;
    end
    @(posedge clk); #1;
    bus.f_req = 1'b0;
    $display("xact collision d_lat=%0d f_lat=%0d", dl, fl);
    check("col_d_lat", 80'(dl), 80'd2);
    check("col_f_lat", 80'(fl), 80'd6);
    check("col_fwait", 80'(fw_ok), 80'd1);
    check("col_d_rdata", 80'(bus.d_rdata), 80'h0000_0008_F230_000F);

    // Bounds
    run_xact(1'b0, 1'b0, 64'd1020, 64'd0, lat, reqcyc, err, wok);
    check("oob_d_lat", 80'(lat), 80'd1);
    check("oob_d_err", 80'(err), 80'd1);
    check("oob_d_noreq", 80'(reqcyc), 80'd0);
    run_xact(1'b0, 1'b0, 64'd1016, 64'd0, lat, reqcyc, err, wok);
    check("edge_d_err", 80'(err), 80'd0);
    run_xact(1'b1, 1'b0, 64'd1014, 64'd0, lat, reqcyc, err, wok);
    check("edge_f_err", 80'(err), 80'd0);
    check("edge_f_lat", 80'(lat), 80'd3);
    run_xact(1'b1, 1'b0, 64'd1015, 64'd0, lat, reqcyc, err, wok);
    check("oob_f_err", 80'(err), 80'd1);
    check("oob_f_noreq", 80'(reqcyc), 80'd0);
    run_xact(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, lat, reqcyc, err, wok);
    check("wrap_d_err", 80'(err), 80'd1);

    // Timeout with the ack held low
    run_xact(1'b0, 1'b0, 64'd8, 64'd0, lat, reqcyc, err, wok);
    ack_en = 1'b0;
    run_xact(1'b0, 1'b0, 64'd0, 64'd0, lat, reqcyc, err, wok);
    check("to_reqcyc", 80'(reqcyc), 80'd15);
    check("to_lat", 80'(lat), 80'd16);
    check("to_err", 80'(err), 80'd1);
    check("to_rdata_kept", 80'(bus.d_rdata), 80'h0000_0008_F230_000F);
    quiet = 1'b1;
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_done || bus.f_done || bus.mem_req) quiet = 1'b0;
    end
    stray_ack = 1'b0;
    check("stray_ignored", 80'(quiet), 80'd1);
    ack_en = 1'b1;
    run_xact(1'b0, 1'b1, 64'd0, 64'h1122_3344_5566_7788, lat, reqcyc, err, wok);
    run_xact(1'b0, 1'b0, 64'd0, 64'd0, lat, reqcyc, err, wok);
    check("post_to_lat", 80'(lat), 80'd2);
    check("post_to_rdata", 80'(bus.d_rdata), 80'h1122_3344_5566_7788);

    // Reset while stalled in the second fetch beat
    @(posedge clk); #1;
    bus.f_req = 1'b1; bus.f_addr = 64'd10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ack_en = 1'b0;
    check("f1_addr", 80'(bus.mem_addr), 80'd18);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_mem_req", 80'({bus.mem_req, bus.mem_we}), 80'd0);
    check("mrst_done", 80'({bus.f_done, bus.f_err, bus.d_done, bus.d_err}), 80'd0);
    check("mrst_mem_addr", 80'(bus.mem_addr), 80'd0);
    check("mrst_rdata", bus.f_rdata | 80'(bus.d_rdata), 80'd0);
    bus.f_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ack_en = 1'b1;
    b0 = nbeat;
    run_xact(1'b1, 1'b0, 64'd10, 64'd0, lat, reqcyc, err, wok);
    check("restart_beat0", 80'(beat_log[b0[7:0]]), 80'd10);
    check("restart_lat", 80'(lat), 80'd3);
    check("restart_rdata", bus.f_rdata, 80'h0000_0000_0000_0008_F230);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single 64-bit unified memory port between the pipeline's two memory users: the fetch stage (10-byte instruction reads) and the memory stage (8-byte data reads and writes). It issues fetch reads as two memory beats and gives data accesses strict priority. It enforces address bounds and a per-beat ack timeout. It exports wait signals that the pipeline hazard controller uses to stall F and M.

## Interface
- MEM_BYTES, 1024: memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- TIMEOUT, 15: maximum wait cycles per memory beat before abort; must be at least 1.

- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- f_req  in  1  fetch read request; level, held until f_done
- f_addr  in  64  instruction byte address; stable while f_req is high
- f_done  out  1  one-cycle pulse: fetch transaction complete
- f_err  out  1  valid with f_done: address out of range or timeout (pipeline maps this to SADR)
- f_rdata  out  80  instruction bytes; [7:0] is the byte at f_addr (little-endian); held until next f_done
- d_req  in  1  data request; level, held until d_done
- d_we  in  1  1 = write (rmmovq/pushq/call), 0 = read
- d_addr  in  64  data byte address
- d_wdata  in  64  write data
- d_done  out  1  one-cycle pulse: data transaction complete
- d_err  out  1  valid with d_done
- d_rdata  out  64  read data; held until next d_done
- f_wait  out  1  f_req & ~f_done (combinational); feeds the F stall
- m_wait  out  1  d_req & ~d_done (combinational); feeds the M stall
- mem_req  out  1  memory beat request; held until mem_ack
- mem_we  out  1  beat is a write
- mem_addr  out  64  beat byte address; memory returns or accepts 8 bytes from here, unaligned allowed
- mem_wdata  out  64  beat write data
- mem_rdata  in  64  beat read data; valid when mem_ack is high
- mem_ack  in  1  beat complete; sampled on the rising edge

## Operation
- States: IDLE, D_ACC, F_BEAT0, F_BEAT1, RESP.
- IDLE: each request sampled here starts a new transaction. Priority is d_req, then f_req.
  - Data request: if d_addr+8 > MEM_BYTES, go directly to RESP with err=1 and issue no beat. Otherwise go to D_ACC with mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata.
  - Fetch request: if f_addr+10 > MEM_BYTES, go to RESP with err=1. Otherwise go to F_BEAT0 with mem_addr=f_addr, mem_we=0.
- D_ACC: on mem_ack, capture mem_rdata into d_rdata (reads only) and go to RESP.
- F_BEAT0: on mem_ack, capture f_rdata[63:0]=mem_rdata, set mem_addr=f_addr+8, and go to F_BEAT1. mem_req stays high across the beat boundary.
- F_BEAT1: on mem_ack, capture f_rdata[79:64]=mem_rdata[15:0] and go to RESP.
- A fetch transaction is not interruptible. A d_req that arrives during a fetch waits until RESP has passed through IDLE.
- RESP: pulse the owning done signal together with err, deassert mem_req, and go to IDLE.
- Timeout: a wait counter clears on every beat start and increments each cycle mem_req is high without mem_ack. When it reaches TIMEOUT, drop mem_req and go to RESP with err=1. f_rdata and d_rdata are not updated on timeout.
- A stray mem_ack in IDLE or RESP, such as a late ack after an abort, is ignored.
- Address arithmetic is 64-bit unsigned. A bound check whose sum overflows counts as out of range.
- On reset: state=IDLE and counter=0. mem_req, mem_we, f_done, f_err, d_done and d_err are 0. mem_addr, mem_wdata, f_rdata and d_rdata are 0. Reset takes effect mid-transaction with no done pulse; the memory must tolerate an abandoned beat.

## Timing
- All outputs are registered except f_wait and m_wait.
- Data access, request sampled in IDLE at edge N with W wait cycles: mem_req is high from N+1 to N+1+W, and d_done is high in the cycle after edge N+2+W. Zero-wait latency is 2 cycles.
- Fetch, zero-wait: f_done is high in the cycle after edge N+3.
- Out of range: done and err are high in the cycle after edge N+1, and mem_req never rises.
- The requester must update its req, address and data on the edge that ends the done cycle; the arbiter is back in IDLE and samples them there. This gives back-to-back transactions a 1-cycle IDLE gap.
- When both requests are pending in IDLE, data is served first and fetch starts in the IDLE following the data RESP.

## Test plan
- Data write then read: write d_addr=8, d_wdata=15 with zero-wait memory, then read d_addr=8. Required: d_done 2 cycles after each request, d_rdata=15, d_err=0.
- Fetch: f_addr=10 with memory holding bytes 10..19 = 0x30,0xF2,0x08,0,...,0. Required: beats at 10 and 18, f_rdata[15:0]=0xF230, f_done 3 cycles after the request.
- Collision: d_req and f_req both rise in the same IDLE cycle. Required: data is served first, then fetch; f_wait stays high throughout the data transaction.
- Bounds: d_addr=1020 with MEM_BYTES=1024. Required: d_done and d_err next+1 cycle with no mem_req. f_addr=1014 passes; f_addr=1015 errors.
- Timeout: mem_ack is held low with TIMEOUT=15. Required: mem_req drops after 15 wait cycles, done and err pulse, and a later stray mem_ack is ignored.
- Reset during F_BEAT1: assert reset_n=0. Required: all outputs are 0 on the next edge, no f_done, and the next f_req restarts at F_BEAT0.
